mig_app_ctrl: RTL and testbench

Request sequencer between user logic and the MIG 7-series DDR3 user (app) interface. It accepts one write or read request at a time over a valid/ready port. It drives app_cmd/app_en/app_wdf_* under the MIG app_rdy/app_wdf_rdy rules, tracks outstanding reads, and returns read data in order. It sits directly upstream of mig_7series_0 and runs in the MIG ui_clk domain.

---
 rtl/mig_app_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_mig_app_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mig_app_ctrl.sv
// Request sequencer between user logic and the MIG 7-series DDR3 app interface.
// Optional watchdog enabled by defining MIG_APP_CTRL_TIMEOUT_EN.
module mig_app_ctrl #(
  parameter int MAX_RD_OUTSTANDING = 8,
  parameter int TIMEOUT_CYCLES     = 4096
) (
  input  logic         ui_clk,
  input  logic         ui_clk_sync_rst,
  input  logic         init_calib_complete,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [27:0]  req_addr,
  input  logic [127:0] req_wdata,
  input  logic [15:0]  req_wmask,
  output logic         rsp_valid,
  output logic [127:0] rsp_rdata,
  output logic [27:0]  app_addr,
  output logic [2:0]   app_cmd,
  output logic         app_en,
  output logic [127:0] app_wdf_data,
  output logic [15:0]  app_wdf_mask,
  output logic         app_wdf_wren,
  output logic         app_wdf_end,
  input  logic         app_rdy,
  input  logic         app_wdf_rdy,
  input  logic [127:0] app_rd_data,
  input  logic         app_rd_data_valid,
  input  logic         app_rd_data_end,
  output logic [3:0]   rd_pending,
  output logic         timeout_err,
  output logic [1:0]   state_dbg
);

  // Handshake: a request transfers on the rising edge where req_valid and
  // req_ready are both high; app_en/app_wdf_wren hold until app_rdy/app_wdf_rdy.
  typedef enum logic [1:0] {CALIB = 2'd0, IDLE = 2'd1, WR = 2'd2, RD = 2'd3} state_t;

  localparam logic [3:0] RD_MAX = 4'(MAX_RD_OUTSTANDING);

  state_t         state_q, state_d;
  logic           req_ready_q, req_ready_d;
  logic           app_en_q, app_en_d;
  logic           wren_q, wren_d;
  logic           wend_q, wend_d;
  logic [2:0]     cmd_q, cmd_d;
  logic [27:0]    addr_q, addr_d;
  logic [127:0]   wdata_q, wdata_d;
  logic [15:0]    wmask_q, wmask_d;
  logic [3:0]     rd_pending_q, rd_pending_d;
  logic           rsp_valid_q;
  logic [127:0]   rsp_rdata_q;
  logic           accept;
  logic           rd_inc;
  logic           rd_dec;
  logic           unused_addr_lsb;

  assign unused_addr_lsb = ^req_addr[2:0];

  if (MAX_RD_OUTSTANDING < 1 || MAX_RD_OUTSTANDING > 15 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 8191) begin : g_params_out_of_range
  end

  always_comb begin
    state_d      = state_q;
    app_en_d     = app_en_q;
    wren_d       = wren_q;
    wend_d       = wend_q;
    cmd_d        = cmd_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    accept       = (state_q == IDLE) && req_valid && req_ready_q;
    rd_inc       = (state_q == RD) && app_en_q && app_rdy;
    rd_dec       = app_rd_data_valid && app_rd_data_end;
    rd_pending_d = rd_pending_q;
    req_ready_d  = 1'b0;

    case (state_q)
      CALIB: begin
        if (init_calib_complete) state_d = IDLE;
      end
      IDLE: begin
        // An advertised req_ready is honoured even if calibration drops that cycle.
        if (accept) begin
          addr_d   = {req_addr[27:3], 3'b000};
          wdata_d  = req_wdata;
          wmask_d  = req_wmask;
          app_en_d = 1'b1;
          if (req_we) begin
            state_d = WR;
            cmd_d   = 3'b000;
            wren_d  = 1'b1;
            wend_d  = 1'b1;
          end else begin
            state_d = RD;
            cmd_d   = 3'b001;
          end
        end else if (!init_calib_complete) begin
          state_d = CALIB;
        end
      end
      WR: begin
        if (app_en_q && app_rdy) app_en_d = 1'b0;
        if (wren_q && app_wdf_rdy) begin
          wren_d = 1'b0;
          wend_d = 1'b0;
        end
        if (!app_en_d && !wren_d) state_d = IDLE;
      end
      RD: begin
        if (app_en_q && app_rdy) begin
          app_en_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = CALIB;
    endcase

    if (rd_inc && !rd_dec) begin
      rd_pending_d = rd_pending_q + 4'd1;
    end else if (rd_dec && !rd_inc && (rd_pending_q != 4'd0)) begin
      rd_pending_d = rd_pending_q - 4'd1;
    end

    req_ready_d = (state_d == IDLE) && init_calib_complete && (rd_pending_d < RD_MAX);
  end

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      state_q      <= CALIB;
      req_ready_q  <= 1'b0;
      app_en_q     <= 1'b0;
      wren_q       <= 1'b0;
      wend_q       <= 1'b0;
      cmd_q        <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      rd_pending_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      app_en_q     <= app_en_d;
      wren_q       <= wren_d;
      wend_q       <= wend_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      rd_pending_q <= rd_pending_d;
      rsp_valid_q  <= app_rd_data_valid;
      rsp_rdata_q  <= app_rd_data;
    end
  end

`ifdef MIG_APP_CTRL_TIMEOUT_EN
  localparam logic [12:0] TO_LIMIT = 13'(TIMEOUT_CYCLES);

  logic [12:0] to_cnt_q, to_cnt_d;
  logic        timeout_err_q, timeout_err_d;

  // Counter saturates at the limit; the flag stays set until reset.
  always_comb begin
    to_cnt_d      = '0;
    timeout_err_d = timeout_err_q;
    if ((state_q == WR) || (state_q == RD)) begin
      to_cnt_d = (to_cnt_q != TO_LIMIT) ? to_cnt_q + 13'd1 : to_cnt_q;
      if (to_cnt_d == TO_LIMIT) timeout_err_d = 1'b1;
    end
  end

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign req_ready    = req_ready_q;
  assign app_en       = app_en_q;
  assign app_wdf_wren = wren_q;
  assign app_wdf_end  = wend_q;
  assign app_cmd      = cmd_q;
  assign app_addr     = addr_q;
  assign app_wdf_data = wdata_q;
  assign app_wdf_mask = wmask_q;
  assign rd_pending   = rd_pending_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_mig_app_ctrl.sv
// Scoreboard bench for mig_app_ctrl: directed requests, queued expectations,
// monitors on the app command, write-data and read-response channels.
module tb_mig_app_ctrl;

  localparam int TB_TIMEOUT = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         icc;
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [27:0]  req_addr;
  logic [127:0] req_wdata;
  logic [15:0]  req_wmask;
  logic         rsp_valid;
  logic [127:0] rsp_rdata;
  logic [27:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic         app_rdy;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         app_rd_data_end;
  logic [3:0]   rd_pending;
  logic         timeout_err;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [30:0]  exp_cmd_q[$];
  logic [143:0] exp_wdf_q[$];
  logic [127:0] exp_rsp_q[$];

  always #5 clk = ~clk;

  mig_app_ctrl #(.MAX_RD_OUTSTANDING(8), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .ui_clk(clk), .ui_clk_sync_rst(rst), .init_calib_complete(icc),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end),
    .rd_pending(rd_pending), .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event seen with no expectation queued", name);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rd_pattern(input int i);
    return {4{32'hC0DE_0000 + 32'(i)}};
  endfunction

  // Monitors sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (app_en && app_rdy) begin
        if (exp_cmd_q.size() == 0) fail_now("app_cmd_unexpected");
        else chk("app_cmd_addr", {app_cmd, app_addr}, exp_cmd_q.pop_front());
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        chk("app_wdf_end", app_wdf_end, 1'b1);
        if (exp_wdf_q.size() == 0) fail_now("app_wdf_unexpected");
        else chk("app_wdf_data_mask", {app_wdf_data, app_wdf_mask}, exp_wdf_q.pop_front());
      end
      if (rsp_valid) begin
        if (exp_rsp_q.size() == 0) fail_now("rsp_unexpected");
        else chk("rsp_rdata", rsp_rdata, exp_rsp_q.pop_front());
      end
    end
  end

  task automatic do_req(input logic we, input logic [27:0] addr,
                        input logic [127:0] data, input logic [15:0] mask);
    int budget;
    logic [2:0] cmd;
    budget = 200;
    while (!req_ready && budget > 0) begin
      tick();
      budget--;
    end
    if (!req_ready) begin
      fail_now("req_ready_wait_expired");
      return;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    req_wmask = mask;
    cmd = we ? 3'b000 : 3'b001;
    exp_cmd_q.push_back({cmd, addr[27:3], 3'b000});
    if (we) exp_wdf_q.push_back({data, mask});
    tick();
    req_valid = 1'b0;
    chk("app_en_after_accept", app_en, 1'b1);
  endtask

  task automatic return_burst(input logic [127:0] data);
    app_rd_data       = data;
    app_rd_data_valid = 1'b1;
    app_rd_data_end   = 1'b1;
    exp_rsp_q.push_back(data);
  endtask

  task automatic end_burst();
    app_rd_data_valid = 1'b0;
    app_rd_data_end   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1'b0);
    chk({tag, "_app_strobes"}, {app_en, app_wdf_wren, app_wdf_end}, 3'b000);
    chk({tag, "_app_cmd"}, app_cmd, 3'b000);
    chk({tag, "_app_addr"}, app_addr, 28'h0);
    chk({tag, "_app_wdf"}, {app_wdf_data, app_wdf_mask}, 144'h0);
    chk({tag, "_rsp"}, {rsp_valid, rsp_rdata}, 129'h0);
    chk({tag, "_rd_pending"}, rd_pending, 4'd0);
    chk({tag, "_timeout_err"}, timeout_err, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: bench did not finish in time");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int viol;
    rst = 1'b1; icc = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    app_rd_data = '0; app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Calibration gate
    viol = 0;
    req_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (req_ready || app_en) viol++;
    end
    chk("calib_gate_violations", viol, 0);
    req_valid = 1'b0;
    icc = 1'b1;
    tick();
    chk("calib_done_req_ready", req_ready, 1'b1);

    // Single write, both handshakes immediate
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    do_req(1'b1, 28'h18, 128'habababab, 16'h0);
    chk("wr_strobes", {app_en, app_wdf_wren, app_wdf_end, app_cmd}, {3'b111, 3'b000});
    chk("wr_addr", app_addr, 28'h18);
    tick();
    chk("wr_strobes_one_cycle", {app_en, app_wdf_wren, app_wdf_end}, 3'b000);
    chk("wr_ready_back", req_ready, 1'b1);

    // Data accepted first, command delayed
    app_rdy = 1'b0; app_wdf_rdy = 1'b1;
    do_req(1'b1, 28'h47, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 16'h00F0);
    tick();
    chk("split_a_strobes", {app_en, app_wdf_wren, app_wdf_end}, 3'b100);
    chk("split_a_ready_low", req_ready, 1'b0);
    tick(4);
    chk("split_a_hold", {app_en, app_addr, app_cmd}, {1'b1, 28'h40, 3'b000});
    app_rdy = 1'b1;
    tick();
    chk("split_a_done", {app_en, req_ready}, 2'b01);

    // Command accepted first, data delayed
    app_rdy = 1'b1; app_wdf_rdy = 1'b0;
    do_req(1'b1, 28'h88, 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000, 16'h8001);
    tick();
    chk("split_b_strobes", {app_en, app_wdf_wren, app_wdf_end}, 3'b011);
    chk("split_b_ready_low", req_ready, 1'b0);
    tick(4);
    chk("split_b_hold", {app_wdf_wren, app_wdf_data, app_wdf_mask},
        {1'b1, 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000, 16'h8001});
    app_wdf_rdy = 1'b1;
    tick();
    chk("split_b_done", {app_wdf_wren, app_wdf_end, req_ready}, 3'b001);

    // Read-back
    do_req(1'b1, 28'hF0, 128'habcdabcdabcdabcdabcd, 16'h0);
    tick();
    do_req(1'b0, 28'hF5, '0, '0);
    chk("rd_cmd_addr", {app_cmd, app_addr}, {3'b001, 28'hF0});
    tick();
    chk("rd_pending_one", rd_pending, 4'd1);
    tick(2);
    return_burst(128'habcdabcdabcdabcdabcd);
    tick();
    end_burst();
    chk("rsp_latency", rsp_valid, 1'b1);
    chk("rd_pending_zero", rd_pending, 4'd0);
    tick();
    chk("rsp_one_cycle", rsp_valid, 1'b0);

    // Outstanding limit
    for (int i = 0; i < 8; i++) do_req(1'b0, 28'(32'h1000 + i * 8), '0, '0);
    tick(2);
    chk("limit_pending", rd_pending, 4'd8);
    chk("limit_ready_low", req_ready, 1'b0);
    return_burst(rd_pattern(0));
    tick();
    end_burst();
    chk("limit_pending_dec", rd_pending, 4'd7);
    chk("limit_ready_back", req_ready, 1'b1);
    for (int i = 1; i < 8; i++) begin
      return_burst(rd_pattern(i));
      tick();
    end
    end_burst();
    tick();
    chk("limit_drained", rd_pending, 4'd0);

    // Increment and decrement on the same edge
    do_req(1'b0, 28'h300, '0, '0);
    tick();
    do_req(1'b0, 28'h308, '0, '0);
    return_burst(rd_pattern(20));
    tick();
    end_burst();
    chk("inc_dec_same_cycle", rd_pending, 4'd1);
    return_burst(rd_pattern(21));
    tick();
    end_burst();
    chk("inc_dec_drained", rd_pending, 4'd0);

    // Unsolicited return at zero saturates but still forwards
    return_burst(rd_pattern(30));
    tick();
    end_burst();
    chk("sat_pending", rd_pending, 4'd0);
    chk("sat_rsp_valid", rsp_valid, 1'b1);

    // Calibration loss while idle
    tick();
    icc = 1'b0;
    tick();
    chk("calib_drop_ready", req_ready, 1'b0);
    tick(3);
    chk("calib_drop_hold", {req_ready, app_en}, 2'b00);
    icc = 1'b1;
    tick();
    chk("calib_regain_ready", req_ready, 1'b1);

`ifdef MIG_APP_CTRL_TIMEOUT_EN
    app_rdy = 1'b0; app_wdf_rdy = 1'b1;
    do_req(1'b1, 28'h500, 128'h5A5A, 16'h0);
    tick(15);
    chk("timeout_before_limit", timeout_err, 1'b0);
    tick();
    chk("timeout_at_limit", timeout_err, 1'b1);
    app_rdy = 1'b1;
    tick();
    chk("timeout_cmd_done", {app_en, req_ready}, 2'b01);
    tick(3);
    chk("timeout_sticky", timeout_err, 1'b1);
`endif

    // Reset with a read outstanding
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    do_req(1'b0, 28'h700, '0, '0);
    tick();
    chk("pre_reset_pending", rd_pending, 4'd1);
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    tick();
    chk("post_reset_ready", req_ready, 1'b1);

    tick(5);
    chk("cmd_queue_empty", exp_cmd_q.size(), 0);
    chk("wdf_queue_empty", exp_wdf_q.size(), 0);
    chk("rsp_queue_empty", exp_rsp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
